// File: rtl/phy_tx_sched.sv
// Two-requester round-robin byte scheduler that issues one start/data pulse to the
// PHY every BYTE_CYCLES clocks within a burst and idles GAP_CYCLES between bursts.
module phy_tx_sched #(
    parameter int unsigned BYTE_CYCLES = 8,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       start,
    output logic [7:0] data,
    output logic       busy,
    output logic       grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    // A last byte waits one extra cycle so the next burst starts B+G+2 after it.
    localparam logic [7:0] WAIT_LOAD      = 8'(BYTE_CYCLES - 2);
    localparam logic [7:0] WAIT_LOAD_LAST = 8'(BYTE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD       = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic       start_q, start_d;
    logic [7:0] data_q, data_d;
    logic       busy_q, busy_d;

    logic       sel_valid_s;
    logic [7:0] sel_data_s;
    logic       sel_last_s;
    logic       hs_s;

    assign sel_valid_s = grant_q ? req1_valid : req0_valid;
    assign sel_data_s  = grant_q ? req1_data  : req0_data;
    assign sel_last_s  = grant_q ? req1_last  : req0_last;
    assign hs_s        = (state_q == S_ISSUE) && sel_valid_s;

    assign req0_ready = (state_q == S_ISSUE) && !grant_q && req0_valid;
    assign req1_ready = (state_q == S_ISSUE) &&  grant_q && req1_valid;

    assign start = start_q;
    assign data  = data_q;
    assign busy  = busy_q;
    assign grant = grant_q;

    // Next-state, arbitration and pacing counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        start_d = 1'b0;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (en && (req0_valid || req1_valid)) begin
                    grant_d = (req0_valid && req1_valid) ? ~grant_q : req1_valid;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (hs_s) begin
                    start_d = 1'b1;
                    data_d  = sel_data_s;
                    last_d  = sel_last_s;
                    cnt_d   = sel_last_s ? WAIT_LOAD_LAST : WAIT_LOAD;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    if (!last_q) begin
                        state_d = S_ISSUE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            grant_q <= 1'b1;
            last_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 8'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            start_q <= start_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_phy_tx_sched.sv
// Directed scoreboard bench for phy_tx_sched: expected bytes, grants and start spacing
// are queued as stimulus is issued and popped when the scheduler pulses start.
module tb_phy_tx_sched;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_last, req1_last;
    logic       req0_ready, req1_ready;
    logic       start;
    logic [7:0] data;
    logic       busy;
    logic       grant;

    logic       g0_req0_ready, g0_req1_ready;
    logic       g0_start;
    logic [7:0] g0_data;
    logic       g0_busy;
    logic       g0_grant;

    phy_tx_sched #(.BYTE_CYCLES(8), .GAP_CYCLES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .start(start), .data(data), .busy(busy), .grant(grant)
    );

    phy_tx_sched #(.BYTE_CYCLES(8), .GAP_CYCLES(0)) u_dut_g0 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last),
        .req0_ready(g0_req0_ready), .req1_ready(g0_req1_ready),
        .start(g0_start), .data(g0_data), .busy(g0_busy), .grant(g0_grant)
    );

    typedef struct {
        logic [7:0] byte_v;
        logic       gnt;
        int         gap;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] src0[$];
    logic [8:0] src1[$];
    logic       hold0;
    int         test_cnt;
    int         fail_cnt;
    int         cyc;
    int         last_start_cyc;
    logic       prev_start;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        test_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [7:0] b, input logic g, input int gap);
        exp_t e;
        e.byte_v = b;
        e.gnt    = g;
        e.gap    = gap;
        exp_q.push_back(e);
    endtask

    // One clock: note handshakes, advance, retire accepted bytes, drive queue heads.
    task automatic step();
        logic hs0, hs1;
        @(negedge clk);
        hs0 = req0_ready;
        hs1 = req1_ready;
        @(posedge clk);
        #1;
        if (hs0 && src0.size() > 0) void'(src0.pop_front());
        if (hs1 && src1.size() > 0) void'(src1.pop_front());
        req0_valid = !hold0 && (src0.size() > 0);
        req0_data  = (src0.size() > 0) ? src0[0][7:0] : 8'h00;
        req0_last  = (src0.size() > 0) ? src0[0][8]   : 1'b0;
        req1_valid = (src1.size() > 0);
        req1_data  = (src1.size() > 0) ? src1[0][7:0] : 8'h00;
        req1_last  = (src1.size() > 0) ? src1[0][8]   : 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        src0.delete();
        src1.delete();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            done = (exp_q.size() == 0) && (src0.size() == 0) && (src1.size() == 0) && !busy;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_src0(input int n, input string tag);
        logic done;
        done = (src0.size() == n);
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            done = (src0.size() == n);
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    // Start monitor: scoreboard pop, spacing and per-cycle invariants.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
        chk("start_b2b", 32'(start & prev_start), 32'd0);
        prev_start = start;
        if (start) begin
            test_cnt++;
            assert (exp_q.size() != 0) else begin
                fail_cnt++;
                $error("FAIL unexpected_start observed data=%0h expected no start", data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("start_data", 32'(data), 32'(e.byte_v));
                chk("start_grant", 32'(grant), 32'(e.gnt));
                chk("start_busy", 32'(busy), 32'd1);
                if (e.gap != 0) chk("start_spacing", 32'(cyc - last_start_cyc), 32'(e.gap));
            end
            last_start_cyc = cyc;
        end
    end

    initial begin
        test_cnt = 0; fail_cnt = 0; cyc = 0; last_start_cyc = 0; prev_start = 1'b0;
        hold0 = 1'b0;
        rst_n = 1'b0; en = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h55; req0_last = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h66; req1_last = 1'b0;

        // Reset values with both requesters asserting valid.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd1);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Three-byte burst from req0 at BYTE_CYCLES spacing.
        src0.push_back({1'b0, 8'hA1}); src0.push_back({1'b0, 8'hA2}); src0.push_back({1'b1, 8'hA3});
        push_exp(8'hA1, 1'b0, 0); push_exp(8'hA2, 1'b0, 8); push_exp(8'hA3, 1'b0, 8);
        wait_idle("idle_burst3");

        // Both valid from reset: req0 first, req1 starts 14 cycles after req0's last.
        do_reset();
        src0.push_back({1'b0, 8'hB0}); src0.push_back({1'b1, 8'hB1});
        src1.push_back({1'b0, 8'hC0}); src1.push_back({1'b1, 8'hC1});
        push_exp(8'hB0, 1'b0, 0); push_exp(8'hB1, 1'b0, 8);
        push_exp(8'hC0, 1'b1, 14); push_exp(8'hC1, 1'b1, 8);
        wait_idle("idle_two_bursts");

        // Continuous single-byte bursts alternate requesters.
        src0.push_back({1'b1, 8'hD0}); src0.push_back({1'b1, 8'hD1});
        src1.push_back({1'b1, 8'hE0}); src1.push_back({1'b1, 8'hE1});
        push_exp(8'hD0, 1'b0, 0); push_exp(8'hE0, 1'b1, 14);
        push_exp(8'hD1, 1'b0, 14); push_exp(8'hE1, 1'b1, 14);
        wait_idle("idle_alternate");

        // req0 drops valid mid-burst while req1 waits: stall in ISSUE.
        src0.push_back({1'b0, 8'hF0}); src0.push_back({1'b1, 8'hF1});
        src1.push_back({1'b1, 8'h90});
        push_exp(8'hF0, 1'b0, 0); push_exp(8'hF1, 1'b0, 13); push_exp(8'h90, 1'b1, 14);
        wait_src0(1, "stall_f0_accept");
        hold0 = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            chk("stall_ready1", 32'(req1_ready), 32'd0);
            chk("stall_start", 32'(start), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        hold0 = 1'b0;
        wait_idle("idle_stall");

        // Reset during WAIT of the second byte discards the rest of the burst.
        src0.push_back({1'b0, 8'h10}); src0.push_back({1'b0, 8'h11}); src0.push_back({1'b1, 8'h12});
        push_exp(8'h10, 1'b0, 0); push_exp(8'h11, 1'b0, 8); push_exp(8'h12, 1'b0, 8);
        wait_src0(1, "rst_h1_accept");
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        exp_q.delete(); src0.delete(); src1.delete();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("midrst_start", 32'(start), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready0", 32'(req0_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("postrst_start", 32'(start), 32'd0);
            chk("postrst_busy", 32'(busy), 32'd0);
        end

        // en dropped during a burst: burst completes, no new grant while en=0.
        do_reset();
        en = 1'b1;
        src0.push_back({1'b0, 8'h20}); src0.push_back({1'b1, 8'h21});
        push_exp(8'h20, 1'b0, 0); push_exp(8'h21, 1'b0, 8);
        wait_src0(1, "en_j0_accept");
        en = 1'b0;
        wait_src0(0, "en_j1_accept");
        src1.push_back({1'b1, 8'h30});
        repeat (7) step();
        chk("g0_busy_s7", 32'(g0_busy), 32'd1);
        step();
        chk("g0_busy_s8", 32'(g0_busy), 32'd0);
        chk("gap_busy_s8", 32'(busy), 32'd1);
        repeat (10) step();
        chk("en0_busy", 32'(busy), 32'd0);
        chk("en0_grant", 32'(grant), 32'd0);
        chk("en0_ready1", 32'(req1_ready), 32'd0);
        chk("en0_g0_grant", 32'(g0_grant), 32'd0);
        chk("en0_g0_ready1", 32'(g0_req1_ready), 32'd0);
        en = 1'b1;
        push_exp(8'h30, 1'b1, 0);
        wait_idle("idle_en_resume");

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/phy_tx_sched.md
PHY_TX_SCHED -- requirements
Module: phy_tx_sched

Interface
REQ-001 Parameter BYTE_CYCLES, default 8: start-to-start spacing, in clk cycles, of consecutive bytes within a burst; legal range 2..255.
REQ-002 Parameter GAP_CYCLES, default 4: extra idle cycles appended after the last byte of a burst; legal range 0..255.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  scheduler enable; sampled only in IDLE.
REQ-006 req0_valid / req1_valid  input  1  requester n has a byte available.
REQ-007 req0_data / req1_data  input  8  byte from requester n.
REQ-008 req0_last / req1_last  input  1  byte is final byte of requester n's burst.
REQ-009 req0_ready / req1_ready  output  1  byte accepted from requester n this cycle (combinational from state).
REQ-010 start  output  1  registered one-cycle pulse to PHY comp start.
REQ-011 data  output  8  registered byte to PHY comp data; valid while start=1, held afterwards.
REQ-012 busy  output  1  registered; high in any state other than IDLE.
REQ-013 grant  output  1  registered; index of current/last granted requester.

Function
REQ-014 States: IDLE, ISSUE, WAIT, GAP.
REQ-015 IDLE: if en=1 and any reqN_valid=1, latch winner into grant, go to ISSUE; else stay.
REQ-016 Arbitration: round-robin; single valid wins; both valid -> requester not equal to current grant wins; grant resets to 1 so req0 wins first tie.
REQ-017 Grant locked for entire burst; other requester never readied until granted burst's last byte accepted.
REQ-018 ISSUE: reqN_ready = reqN_valid for granted N only; on handshake, byte and last captured; start=1 and data=byte next cycle; go to WAIT.
REQ-019 ISSUE with granted valid=0: stall in ISSUE, no start, grant held, busy=1.
REQ-020 WAIT: counts so that next ISSUE handshake can occur exactly BYTE_CYCLES-1 cycles after previous start, giving start-to-start spacing of BYTE_CYCLES when valid stays high.
REQ-021 WAIT end: captured last=0 -> ISSUE; last=1 -> GAP, or IDLE if GAP_CYCLES=0.
REQ-022 GAP: idle GAP_CYCLES cycles, then IDLE; first start of next burst no earlier than BYTE_CYCLES+GAP_CYCLES+2 cycles after previous last start.
REQ-023 start never high on two consecutive cycles; ready never high outside ISSUE; at most one ready high per cycle.
REQ-024 en=0 outside IDLE has no effect; current burst completes.
REQ-025 Single-byte burst (last=1 on first byte) legal; follows REQ-021.
REQ-026 Counter width 8 bits; no wrap permitted within legal parameter range.

Reset
REQ-027 rst_n=0 asynchronously forces: state IDLE, start=0, data=0, busy=0, grant=1, counters 0, req0_ready=req1_ready=0.
REQ-028 Reset mid-burst discards captured byte and remaining burst; no start issued until a new IDLE->ISSUE handshake after rst_n deasserts.

Verification
REQ-029 After reset, req0 streams 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3), BYTE_CYCLES=8 -> start pulses at T+1, T+9, T+17 with data A1,A2,A3; busy high throughout.
REQ-030 req0 and req1 both valid from reset, one 2-byte burst each -> req0 burst completes first, then req1; req1 first start exactly BYTE_CYCLES+GAP_CYCLES+2 = 14 cycles after req0 last start.
REQ-031 Both requesters continuously valid with 1-byte bursts -> grant alternates 0,1,0,1; no requester served twice in a row.
REQ-032 req0 drops valid for 5 cycles mid-burst while req1 valid -> scheduler stalls in ISSUE, req1_ready stays 0, no start during stall.
REQ-033 rst_n pulsed low during WAIT of 2nd byte -> start, busy, ready low immediately; after release, no start until new request.
REQ-034 GAP_CYCLES=0, en=0 during burst -> burst completes, then IDLE with busy=0 and no new grant while en=0.
